// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_STEP      = 4;
    localparam int XLEN_DEFAULT = 32;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

    // Width able to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through prefetch queue; when empty the head holds the last entry
// that left the queue so decode sees stable values.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  entry_t                  push_data_i,
    input  logic                    pop_i,
    input  logic                    clear_i,
    output entry_t                  head_o,
    output logic                    head_valid_o,
    output logic [cnt_w(DEPTH)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    entry_t        mem_q [DEPTH];
    entry_t        hold_q, hold_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty && !clear_i;
    assign do_push = push_i && !clear_i && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (!empty) begin
                hold_d = mem_q[rd_ptr_q];
            end
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                hold_d   = mem_q[rd_ptr_q];
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: it is only visible through a non-empty head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o       = empty ? hold_q : mem_q[rd_ptr_q];
    assign head_valid_o = !empty;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited in-order requests,
// tags responses with their PC and discards responses orphaned by a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    instr_pc
);

    localparam int CW = cnt_w(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count;
    logic [CW:0]     in_use;
    logic            req_fire, resp_fire, push, pop, q_valid;
    entry_t          push_entry, head;

    assign target = {redirect_pc[XLEN-1:2], 2'b00};

    // Queued plus outstanding words never exceed DEPTH, so a push always finds room.
    assign in_use         = {1'b0, count} + {1'b0, outst_q};
    assign imem_req_valid = !reset && !redirect && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign resp_fire  = imem_resp_valid && (outst_q != '0);
    assign push       = resp_fire && !redirect && (drop_q == '0);
    assign pop        = q_valid && instr_ready && !redirect;
    assign push_entry = {resp_pc_q, imem_resp_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_fire);
        if (redirect) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            // A response arriving alongside the redirect is already gone.
            drop_d     = outst_q - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
            end
            if (resp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .clear_i      (redirect),
        .head_o       (head),
        .head_valid_o (q_valid),
        .count_o      (count)
    );

    assign instr_valid = q_valid && !redirect;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency memory, queue-based reference model,
// directed corner cases followed by a randomized run.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid, imem_req_ready, imem_resp_valid;
    logic        redirect, instr_valid, instr_ready;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, instr, instr_pc;
    logic        w_req_valid, w_instr_valid;
    logic [31:0] w_req_addr, w_instr, w_instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    // Second instance only exercises PC wrap from a high reset vector.
    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(w_req_addr), .imem_resp_valid(1'b0),
        .imem_resp_data(32'h0), .redirect(1'b0), .redirect_pc(32'h0),
        .instr_valid(w_instr_valid), .instr_ready(1'b0), .instr(w_instr), .instr_pc(w_instr_pc)
    );

    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, rc = 0, first_iv = -1, proto_cnt = 0;
    bit s_reset = 1, s_rq = 0, s_ir = 0, s_redir = 0, rnd_mode = 0;
    logic [31:0] s_rpc = 0;
    int s_lat = 1;

    ent_t        m_q[$];
    mreq_t       mem_q[$];
    logic [31:0] m_fetch_pc, m_resp_pc;
    int          m_out, m_drop;
    logic [31:0] hs_log[$], pop_log[$], w_log[$];
    bit          smp_iv, smp_rv, smp_resp;
    logic [31:0] smp_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fetch_pc = 32'h0;
        m_resp_pc  = 32'h0;
        m_out      = 0;
        m_drop     = 0;
    endtask

    task automatic drive();
        if (rnd_mode) begin
            s_rq    = ($urandom_range(0, 9) < 7);
            s_ir    = ($urandom_range(0, 9) < 6);
            s_redir = ($urandom_range(0, 24) == 0);
            s_rpc   = $urandom;
            s_lat   = $urandom_range(1, 4);
        end
        reset          = s_reset;
        imem_req_ready = s_rq;
        instr_ready    = s_ir;
        redirect       = s_redir;
        redirect_pc    = s_rpc;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (!s_reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    endtask

    task automatic check_update();
        bit exp_rv, exp_iv, rfire;
        logic [31:0] tgt;
        smp_iv   = instr_valid;
        smp_rv   = imem_req_valid;
        smp_addr = imem_req_addr;
        smp_resp = imem_resp_valid;
        if (w_req_valid) w_log.push_back(w_req_addr);
        if (reset) begin
            chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
            chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
            chk("rst_req_addr", imem_req_addr, 32'h0);
            chk("rst_wrap_addr", w_req_addr, 32'hFFFF_FFF8);
            chk("rst_wrap_instr", w_instr ^ w_instr_pc, 32'h0);
            chk("rst_wrap_iv", {31'h0, w_instr_valid}, 32'h0);
            model_reset();
            return;
        end
        exp_rv = !redirect && (m_q.size() + m_out < DEPTH);
        exp_iv = (m_q.size() > 0) && !redirect;
        chk("req_valid", {31'h0, imem_req_valid}, {31'h0, exp_rv});
        chk("req_addr", imem_req_addr, m_fetch_pc);
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, exp_iv});
        if (exp_iv) begin
            chk("instr_pc", instr_pc, m_q[0].pc);
            chk("instr", instr, m_q[0].instr);
        end
        if (imem_req_valid && imem_req_ready) begin
            hs_log.push_back(imem_req_addr);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + s_lat});
        end
        if (instr_valid && instr_ready) pop_log.push_back(instr_pc);
        if (instr_valid && first_iv < 0) first_iv = rc;
        if (imem_resp_valid && m_out == 0) proto_cnt++;

        rfire = imem_resp_valid && (m_out > 0);
        if (redirect) begin
            tgt = {redirect_pc[31:2], 2'b00};
            m_q.delete();
            m_fetch_pc = tgt;
            m_resp_pc  = tgt;
            if (rfire) m_out--;
            m_drop = m_out;
        end else begin
            if (exp_iv && instr_ready) void'(m_q.pop_front());
            if (rfire) begin
                m_out--;
                if (m_drop > 0) m_drop--;
                else begin
                    m_q.push_back('{pc: m_resp_pc, instr: mem_word(m_resp_pc)});
                    m_resp_pc += 32'd4;
                end
            end
            if (exp_rv && imem_req_ready) begin
                m_fetch_pc += 32'd4;
                m_out++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        check_update();
        cyc++;
        rc++;
    endtask

    task automatic clear_logs();
        hs_log.delete();
        pop_log.delete();
        w_log.delete();
        first_iv = -1;
        rc = 0;
    endtask

    task automatic do_reset();
        s_reset = 1;
        s_redir = 0;
        repeat (2) step();
        mem_q.delete();
        s_reset = 0;
        clear_logs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        redirect = 0; redirect_pc = 0; instr_ready = 0;

        // Streaming with single-cycle memory.
        do_reset();
        s_rq = 1; s_ir = 1; s_lat = 1;
        repeat (12) step();
        chk("A_first_addr", qat(hs_log, 0), 32'h0);
        chk("A_fill_cycles", first_iv, 32'd2);
        for (int k = 0; k < 8; k++) chk("A_pc_seq", qat(pop_log, k), 32'(4 * k));
        chk("A_one_per_cycle", pop_log.size(), 32'd10);
        chk("W_addr0", qat(w_log, 0), 32'hFFFF_FFF8);
        chk("W_addr1", qat(w_log, 1), 32'hFFFF_FFFC);
        chk("W_addr2", qat(w_log, 2), 32'h0000_0000);

        // Credit limit with a stalled decoder.
        do_reset();
        s_rq = 1; s_ir = 0; s_lat = 1;
        repeat (8) step();
        chk("B_req_count", hs_log.size(), 32'd4);
        chk("B_req_stalled", {31'h0, smp_rv}, 32'h0);
        s_ir = 1;
        repeat (3) step();
        s_ir = 0;
        repeat (8) step();
        chk("B_pops", pop_log.size(), 32'd3);
        chk("B_req_count2", hs_log.size(), 32'd7);
        chk("B_addr4", qat(hs_log, 4), 32'h10);
        chk("B_addr5", qat(hs_log, 5), 32'h14);
        chk("B_addr6", qat(hs_log, 6), 32'h18);

        // Redirect with two responses in flight, 3-cycle memory.
        do_reset();
        s_rq = 1; s_ir = 1; s_lat = 3;
        repeat (2) step();
        s_redir = 1; s_rpc = 32'h103;
        step();
        chk("C_inflight", hs_log.size(), 32'd2);
        chk("C_no_req_in_R", {31'h0, smp_rv}, 32'h0);
        s_redir = 0;
        repeat (10) step();
        chk("C_next_addr", qat(hs_log, 2), 32'h100);
        chk("C_first_pc", qat(pop_log, 0), 32'h100);
        chk("C_second_pc", qat(pop_log, 1), 32'h104);

        // Redirect coinciding with a response and a would-be pop.
        do_reset();
        s_rq = 1; s_ir = 1; s_lat = 1;
        repeat (6) step();
        s_redir = 1; s_rpc = 32'h2000;
        step();
        chk("D_resp_in_R", {31'h0, smp_resp}, 32'h1);
        chk("D_iv_in_R", {31'h0, smp_iv}, 32'h0);
        s_redir = 0;
        pop_log.delete();
        step();
        chk("D_empty_after", {31'h0, smp_iv}, 32'h0);
        chk("D_resume_addr", smp_addr, 32'h2000);
        chk("D_resume_valid", {31'h0, smp_rv}, 32'h1);
        repeat (4) step();
        chk("D_first_pc", qat(pop_log, 0), 32'h2000);

        // Asynchronous reset with 3 queued and 1 outstanding.
        do_reset();
        s_rq = 1; s_ir = 0; s_lat = 3;
        repeat (6) step();
        chk("E_hs", hs_log.size(), 32'd4);
        @(posedge clk);
        #1;
        chk("E_pre_iv", {31'h0, instr_valid}, 32'h1);
        reset = 1'b1;
        s_reset = 1;
        #1;
        chk("E_async_iv", {31'h0, instr_valid}, 32'h0);
        chk("E_async_rv", {31'h0, imem_req_valid}, 32'h0);
        repeat (2) step();
        s_reset = 0; s_lat = 1; s_ir = 1;
        clear_logs();
        p = proto_cnt;
        step();
        chk("E_stale_resp", {31'h0, smp_resp}, 32'h1);
        chk("E_stale_flag", proto_cnt - p, 32'd1);
        repeat (5) step();
        chk("E_restart_addr", qat(hs_log, 0), 32'h0);
        chk("E_restart_pc", qat(pop_log, 0), 32'h0);

        // Randomized traffic.
        do_reset();
        rnd_mode = 1;
        repeat (3000) step();
        rnd_mode = 0;
        chk("R_activity", {31'h0, pop_log.size() > 100}, 32'h1);
        chk("R_no_proto", proto_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
